// File: rtl/coreriscv_axi4_credit_lrr_arbiter.sv
// Four-input locking round-robin arbiter with per-destination credit gating for multi-beat messages.
// Optional stall watchdog (io_lock_timeout) is built when CORERISCV_AXI4_ARB_WATCHDOG_EN is defined.
`timescale 1ns/1ps
module coreriscv_axi4_credit_lrr_arbiter #(
    parameter int CREDITS = 4,
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       io_in_0_valid,
    output logic       io_in_0_ready,
    input  logic [1:0] io_in_0_bits_header_src,
    input  logic [1:0] io_in_0_bits_header_dst,
    input  logic [1:0] io_in_0_bits_payload_manager_xact_id,
    input  logic [1:0] io_in_0_bits_payload_len,
    input  logic       io_in_1_valid,
    output logic       io_in_1_ready,
    input  logic [1:0] io_in_1_bits_header_src,
    input  logic [1:0] io_in_1_bits_header_dst,
    input  logic [1:0] io_in_1_bits_payload_manager_xact_id,
    input  logic [1:0] io_in_1_bits_payload_len,
    input  logic       io_in_2_valid,
    output logic       io_in_2_ready,
    input  logic [1:0] io_in_2_bits_header_src,
    input  logic [1:0] io_in_2_bits_header_dst,
    input  logic [1:0] io_in_2_bits_payload_manager_xact_id,
    input  logic [1:0] io_in_2_bits_payload_len,
    input  logic       io_in_3_valid,
    output logic       io_in_3_ready,
    input  logic [1:0] io_in_3_bits_header_src,
    input  logic [1:0] io_in_3_bits_header_dst,
    input  logic [1:0] io_in_3_bits_payload_manager_xact_id,
    input  logic [1:0] io_in_3_bits_payload_len,
    input  logic       io_out_ready,
    output logic       io_out_valid,
    output logic [1:0] io_out_bits_header_src,
    output logic [1:0] io_out_bits_header_dst,
    output logic [1:0] io_out_bits_payload_manager_xact_id,
    output logic       io_out_last,
    output logic [1:0] io_chosen,
    input  logic       io_credit_return_valid,
    input  logic [1:0] io_credit_return_dst,
    output logic       io_busy,
`ifdef CORERISCV_AXI4_ARB_WATCHDOG_EN
    output logic       io_lock_timeout,
`endif
    output logic       io_credit_err
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [2:0] CREDIT_MAX = 3'(CREDITS);

    if ((CREDITS < 1) || (CREDITS > 7) || (TIMEOUT < 1) || (TIMEOUT > 255)) begin : g_bad_params
        $error("coreriscv_axi4_credit_lrr_arbiter: CREDITS must be 1..7 and TIMEOUT 1..255");
    end

    // Returns {found, index} of the lowest set bit of a 4-bit request mask.
    function automatic logic [2:0] lowest_set(input logic [3:0] mask);
        logic [2:0] res;
        casez (mask)
            4'b???1: res = 3'b100;
            4'b??10: res = 3'b101;
            4'b?100: res = 3'b110;
            4'b1000: res = 3'b111;
            default: res = 3'b000;
        endcase
        return res;
    endfunction

    // Mask of input indices strictly above the previous grant.
    function automatic logic [3:0] above_mask(input logic [1:0] idx);
        logic [3:0] res;
        case (idx)
            2'd0:    res = 4'b1110;
            2'd1:    res = 4'b1100;
            2'd2:    res = 4'b1000;
            default: res = 4'b0000;
        endcase
        return res;
    endfunction

    state_t     state_r, state_nxt_s;
    logic [1:0] last_grant_r, last_grant_nxt_s;
    logic [1:0] locked_idx_r, locked_idx_nxt_s;
    logic [1:0] beat_cnt_r, beat_cnt_nxt_s;
    logic [2:0] credit_r [4];
    logic [2:0] credit_nxt_s [4];
    logic       credit_err_r, credit_err_set_s;

    logic [3:0] in_valid_s;
    logic [1:0] in_src_s [4];
    logic [1:0] in_dst_s [4];
    logic [1:0] in_xid_s [4];
    logic [1:0] in_len_s [4];
    logic [3:0] eligible_s;
    logic [2:0] hi_pick_s, lo_pick_s;
    logic [1:0] chosen_s;
    logic       out_valid_s, out_last_s, fire_s, idle_fire_s;
    logic [3:0] in_ready_s;
    logic [3:0] dec_s, inc_s;

    // Gather the flat per-input ports into indexable arrays.
    always_comb begin
        in_valid_s  = {io_in_3_valid, io_in_2_valid, io_in_1_valid, io_in_0_valid};
        in_src_s[0] = io_in_0_bits_header_src;
        in_src_s[1] = io_in_1_bits_header_src;
        in_src_s[2] = io_in_2_bits_header_src;
        in_src_s[3] = io_in_3_bits_header_src;
        in_dst_s[0] = io_in_0_bits_header_dst;
        in_dst_s[1] = io_in_1_bits_header_dst;
        in_dst_s[2] = io_in_2_bits_header_dst;
        in_dst_s[3] = io_in_3_bits_header_dst;
        in_xid_s[0] = io_in_0_bits_payload_manager_xact_id;
        in_xid_s[1] = io_in_1_bits_payload_manager_xact_id;
        in_xid_s[2] = io_in_2_bits_payload_manager_xact_id;
        in_xid_s[3] = io_in_3_bits_payload_manager_xact_id;
        in_len_s[0] = io_in_0_bits_payload_len;
        in_len_s[1] = io_in_1_bits_payload_len;
        in_len_s[2] = io_in_2_bits_payload_len;
        in_len_s[3] = io_in_3_bits_payload_len;
    end

    // Eligibility and the round-robin candidates for an IDLE grant.
    always_comb begin
        eligible_s = 4'b0000;
        for (int n = 0; n < 4; n++) begin
            eligible_s[n] = in_valid_s[n] && (credit_r[in_dst_s[n]] != 3'd0);
        end
        hi_pick_s = lowest_set(eligible_s & above_mask(last_grant_r));
        lo_pick_s = lowest_set(eligible_s);
    end

    // Output selection: credit-gated round robin in IDLE, pinned to the owner while LOCKED.
    always_comb begin
        chosen_s    = 2'd0;
        out_valid_s = 1'b0;
        out_last_s  = 1'b0;
        in_ready_s  = 4'b0000;
        case (state_r)
            IDLE: begin
                chosen_s    = hi_pick_s[2] ? hi_pick_s[1:0] : lo_pick_s[1:0];
                out_valid_s = lo_pick_s[2];
                out_last_s  = (in_len_s[chosen_s] == 2'd0);
                for (int n = 0; n < 4; n++) begin
                    in_ready_s[n] = io_out_ready && (chosen_s == 2'(n)) && eligible_s[n];
                end
            end
            LOCKED: begin
                chosen_s    = locked_idx_r;
                out_valid_s = in_valid_s[locked_idx_r];
                out_last_s  = (beat_cnt_r == 2'd0);
                for (int n = 0; n < 4; n++) begin
                    in_ready_s[n] = io_out_ready && (locked_idx_r == 2'(n));
                end
            end
            default: begin
                chosen_s = 2'd0;
            end
        endcase
        fire_s      = out_valid_s && io_out_ready;
        idle_fire_s = fire_s && (state_r == IDLE);
    end

    // Next-state logic for the message lock.
    always_comb begin
        state_nxt_s      = state_r;
        last_grant_nxt_s = last_grant_r;
        locked_idx_nxt_s = locked_idx_r;
        beat_cnt_nxt_s   = beat_cnt_r;
        case (state_r)
            IDLE: begin
                if (fire_s) begin
                    last_grant_nxt_s = chosen_s;
                    if (in_len_s[chosen_s] != 2'd0) begin
                        locked_idx_nxt_s = chosen_s;
                        beat_cnt_nxt_s   = in_len_s[chosen_s] - 2'd1;
                        state_nxt_s      = LOCKED;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOCKED: begin
                if (fire_s && (beat_cnt_r == 2'd0)) begin
                    state_nxt_s = IDLE;
                end else if (fire_s) begin
                    beat_cnt_nxt_s = beat_cnt_r - 2'd1;
                end else begin
                    state_nxt_s = LOCKED;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Credit counters: a same-cycle take and return cancel; a surplus return saturates and flags.
    always_comb begin
        credit_err_set_s = 1'b0;
        dec_s            = 4'b0000;
        inc_s            = 4'b0000;
        for (int d = 0; d < 4; d++) begin
            dec_s[d]        = idle_fire_s && (in_dst_s[chosen_s] == 2'(d));
            inc_s[d]        = io_credit_return_valid && (io_credit_return_dst == 2'(d));
            credit_nxt_s[d] = credit_r[d];
            case ({dec_s[d], inc_s[d]})
                2'b10: credit_nxt_s[d] = credit_r[d] - 3'd1;
                2'b01: begin
                    if (credit_r[d] == CREDIT_MAX) begin
                        credit_err_set_s = 1'b1;
                    end else begin
                        credit_nxt_s[d] = credit_r[d] + 3'd1;
                    end
                end
                default: credit_nxt_s[d] = credit_r[d];
            endcase
        end
    end

    // Lock state and grant history registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            last_grant_r <= 2'd0;
            locked_idx_r <= 2'd0;
            beat_cnt_r   <= 2'd0;
        end else begin
            state_r      <= state_nxt_s;
            last_grant_r <= last_grant_nxt_s;
            locked_idx_r <= locked_idx_nxt_s;
            beat_cnt_r   <= beat_cnt_nxt_s;
        end
    end

    // Credit counters and the sticky credit error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int d = 0; d < 4; d++) begin
                credit_r[d] <= CREDIT_MAX;
            end
            credit_err_r <= 1'b0;
        end else begin
            for (int d = 0; d < 4; d++) begin
                credit_r[d] <= credit_nxt_s[d];
            end
            credit_err_r <= credit_err_r | credit_err_set_s;
        end
    end

`ifdef CORERISCV_AXI4_ARB_WATCHDOG_EN
    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    logic [7:0] stall_cnt_r, stall_cnt_nxt_s;
    logic       lock_timeout_r;

    // Count LOCKED cycles without progress; saturate rather than wrap.
    always_comb begin
        stall_cnt_nxt_s = 8'd0;
        if ((state_r == LOCKED) && !fire_s) begin
            stall_cnt_nxt_s = (stall_cnt_r == 8'hFF) ? stall_cnt_r : (stall_cnt_r + 8'd1);
        end else begin
            stall_cnt_nxt_s = 8'd0;
        end
    end

    // Stall counter and sticky timeout flag; the lock itself is never broken.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_r    <= 8'd0;
            lock_timeout_r <= 1'b0;
        end else begin
            stall_cnt_r    <= stall_cnt_nxt_s;
            lock_timeout_r <= lock_timeout_r | (stall_cnt_nxt_s == TIMEOUT_C);
        end
    end

    assign io_lock_timeout = lock_timeout_r;
`endif

    assign io_in_0_ready                        = in_ready_s[0];
    assign io_in_1_ready                        = in_ready_s[1];
    assign io_in_2_ready                        = in_ready_s[2];
    assign io_in_3_ready                        = in_ready_s[3];
    assign io_out_valid                         = out_valid_s;
    assign io_out_last                          = out_last_s;
    assign io_chosen                            = chosen_s;
    assign io_out_bits_header_src               = in_src_s[chosen_s];
    assign io_out_bits_header_dst               = in_dst_s[chosen_s];
    assign io_out_bits_payload_manager_xact_id  = in_xid_s[chosen_s];
    assign io_busy                              = (state_r == LOCKED);
    assign io_credit_err                        = credit_err_r;

endmodule

// File: tb/tb_coreriscv_axi4_credit_lrr_arbiter.sv
// Scoreboard bench: a message-level reference model predicts each cycle's outputs, a monitor compares.
`timescale 1ns/1ps
module tb_coreriscv_axi4_credit_lrr_arbiter;

    localparam int CREDITS = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] vld;
    logic [1:0] src [4];
    logic [1:0] dst [4];
    logic [1:0] xid [4];
    logic [1:0] len [4];
    logic       oready, ret_v;
    logic [1:0] ret_d;
    wire  [3:0] rdy;
    wire        io_out_valid, io_out_last, io_busy, io_credit_err;
    wire  [1:0] o_src, o_dst, o_xid, io_chosen;
`ifdef CORERISCV_AXI4_ARB_WATCHDOG_EN
    wire        io_lock_timeout;
`endif

    always #5 clk = ~clk;

    coreriscv_axi4_credit_lrr_arbiter dut (
        .clk(clk), .reset(rst),
        .io_in_0_valid(vld[0]), .io_in_0_ready(rdy[0]),
        .io_in_0_bits_header_src(src[0]), .io_in_0_bits_header_dst(dst[0]),
        .io_in_0_bits_payload_manager_xact_id(xid[0]), .io_in_0_bits_payload_len(len[0]),
        .io_in_1_valid(vld[1]), .io_in_1_ready(rdy[1]),
        .io_in_1_bits_header_src(src[1]), .io_in_1_bits_header_dst(dst[1]),
        .io_in_1_bits_payload_manager_xact_id(xid[1]), .io_in_1_bits_payload_len(len[1]),
        .io_in_2_valid(vld[2]), .io_in_2_ready(rdy[2]),
        .io_in_2_bits_header_src(src[2]), .io_in_2_bits_header_dst(dst[2]),
        .io_in_2_bits_payload_manager_xact_id(xid[2]), .io_in_2_bits_payload_len(len[2]),
        .io_in_3_valid(vld[3]), .io_in_3_ready(rdy[3]),
        .io_in_3_bits_header_src(src[3]), .io_in_3_bits_header_dst(dst[3]),
        .io_in_3_bits_payload_manager_xact_id(xid[3]), .io_in_3_bits_payload_len(len[3]),
        .io_out_ready(oready), .io_out_valid(io_out_valid),
        .io_out_bits_header_src(o_src), .io_out_bits_header_dst(o_dst),
        .io_out_bits_payload_manager_xact_id(o_xid), .io_out_last(io_out_last),
        .io_chosen(io_chosen), .io_credit_return_valid(ret_v), .io_credit_return_dst(ret_d),
        .io_busy(io_busy),
`ifdef CORERISCV_AXI4_ARB_WATCHDOG_EN
        .io_lock_timeout(io_lock_timeout),
`endif
        .io_credit_err(io_credit_err)
    );

    typedef struct {
        logic       valid, last, busy, err;
        logic [3:0] rdy;
        logic [1:0] ch, src, dst, xid;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_pass = 0;
    int   n_total = 0;

    // reference model: message-level view of the arbiter
    int m_last, m_idx, m_left;
    int m_credit [4];
    bit m_locked, m_err;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic m_reset();
        m_last = 0; m_idx = 0; m_left = 0; m_locked = 0; m_err = 0;
        for (int d = 0; d < 4; d++) m_credit[d] = CREDITS;
    endtask

    // Predict this cycle's outputs from the current inputs, queue them, then advance the model.
    task automatic model_step();
        exp_t e;
        bit   v, fire;
        int   ch, dec_d, c;
        ch = 0; v = 0;
        e.busy = m_locked; e.err = m_err; e.rdy = 4'b0000;
        if (m_locked) begin
            ch = m_idx; v = vld[ch];
            e.last = (m_left == 1);
            e.rdy[ch] = oready;
        end else begin
            for (int k = 1; k <= 4; k++) begin
                int n;
                n = (m_last + k) % 4;
                if (!v && vld[n] && m_credit[dst[n]] > 0) begin ch = n; v = 1; end
            end
            e.last = (len[ch] == 2'd0);
            e.rdy[ch] = oready && v;
        end
        e.valid = v; e.ch = 2'(ch); e.src = src[ch]; e.dst = dst[ch]; e.xid = xid[ch];
        sb.push_back(e);
        fire = v && oready;
        if (rst) begin
            m_reset();
        end else begin
            dec_d = -1;
            if (fire && !m_locked) begin
                dec_d = int'(dst[ch]);
                m_last = ch;
                if (len[ch] != 2'd0) begin m_locked = 1; m_idx = ch; m_left = int'(len[ch]); end
            end else if (fire) begin
                m_left--;
                if (m_left == 0) m_locked = 0;
            end
            for (int d = 0; d < 4; d++) begin
                c = m_credit[d] - ((d == dec_d) ? 1 : 0) + ((ret_v && int'(ret_d) == d) ? 1 : 0);
                if (c > CREDITS) begin c = CREDITS; m_err = 1; end
                m_credit[d] = c;
            end
        end
    endtask

    // Monitor: compare every presented cycle against the queued prediction.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check("valid", 8'(io_out_valid), 8'(mon_e.valid));
            check("ready", 8'(rdy), 8'(mon_e.rdy));
            check("busy", 8'(io_busy), 8'(mon_e.busy));
            check("credit_err", 8'(io_credit_err), 8'(mon_e.err));
            check("chosen", 8'(io_chosen), 8'(mon_e.ch));
            check("last", 8'(io_out_last), 8'(mon_e.last));
            check("out_src", 8'(o_src), 8'(mon_e.src));
            check("out_dst", 8'(o_dst), 8'(mon_e.dst));
            check("out_xid", 8'(o_xid), 8'(mon_e.xid));
        end
    end

    task automatic adv();
        @(posedge clk); #1;
    endtask

    task automatic cyc();
        model_step();
        @(negedge clk); #1;
    endtask

    task automatic set_all(input logic [3:0] v, input logic [1:0] d, input logic [1:0] l);
        vld = v;
        for (int n = 0; n < 4; n++) begin
            dst[n] = d; len[n] = l; src[n] = 2'(n); xid[n] = 2'(3 - n);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; oready = 1'b1; ret_v = 1'b0; ret_d = 2'd0;
        set_all(4'b0000, 2'd0, 2'd0);
        @(posedge clk); #1;
        m_reset();
        cyc();
        check("reset_busy", 8'(io_busy), 8'd0);
        check("reset_chosen", 8'(io_chosen), 8'd0);
        check("reset_err", 8'(io_credit_err), 8'd0);

        // two single-beat requests: 2 before 0 after reset
        adv(); rst = 1'b0; set_all(4'b0101, 2'd1, 2'd0);
        cyc(); check("t1_first_grant", 8'(io_chosen), 8'd2);
        adv(); cyc(); check("t1_second_grant", 8'(io_chosen), 8'd0);

        // four-beat lock on input 1 while input 3 waits
        adv(); set_all(4'b1010, 2'd0, 2'd0); len[1] = 2'd3;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("t2_locked_chosen", 8'(io_chosen), 8'd1);
            check("t2_last", 8'(io_out_last), 8'((i == 3) ? 1 : 0));
            check("t2_in3_ready", 8'(rdy[3]), 8'd0);
            adv();
        end
        cyc(); check("t2_handoff", 8'(io_chosen), 8'd3);

        // drain destination 2, then a single return re-enables one grant
        adv(); set_all(4'b0001, 2'd2, 2'd0);
        for (int i = 0; i < 4; i++) begin cyc(); check("t3_drain_valid", 8'(io_out_valid), 8'd1); adv(); end
        cyc(); check("t3_blocked", 8'(io_out_valid), 8'd0);
        adv(); ret_v = 1'b1; ret_d = 2'd2;
        cyc(); check("t3_blocked_on_return", 8'(io_out_valid), 8'd0);
        adv(); ret_v = 1'b0;
        cyc(); check("t3_regrant", 8'(io_out_valid), 8'd1);
        adv(); cyc(); check("t3_reblocked", 8'(io_out_valid), 8'd0);

        // same-cycle take and return on destination 3, then surplus return on destination 0
        adv(); set_all(4'b0001, 2'd3, 2'd0);
        cyc(); adv(); cyc(); adv();
        ret_v = 1'b1; ret_d = 2'd3;
        cyc(); adv(); ret_v = 1'b0;
        cyc(); check("t4_credit_a", 8'(io_out_valid), 8'd1); adv();
        cyc(); check("t4_credit_b", 8'(io_out_valid), 8'd1); adv();
        cyc(); check("t4_credit_empty", 8'(io_out_valid), 8'd0); adv();
        vld = 4'b0000; ret_v = 1'b1; ret_d = 2'd0;
        cyc(); adv(); cyc(); adv();
        cyc(); check("t4_err_before", 8'(io_credit_err), 8'd0); adv();
        ret_v = 1'b0;
        cyc(); check("t4_err_sticky", 8'(io_credit_err), 8'd1);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            int d;
            adv();
            rst = ($urandom_range(0, 299) == 0);
            oready = ($urandom_range(0, 3) != 0);
            for (int n = 0; n < 4; n++) begin
                vld[n] = ($urandom_range(0, 9) < 6);
                src[n] = 2'($urandom); dst[n] = 2'($urandom);
                xid[n] = 2'($urandom); len[n] = 2'($urandom);
            end
            d = $urandom_range(0, 3);
            ret_d = 2'(d);
            ret_v = (m_credit[d] < CREDITS) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 49) == 0);
            cyc();
        end

        // reset in the middle of a four-beat message
        adv(); rst = 1'b1; ret_v = 1'b0; oready = 1'b1; set_all(4'b0000, 2'd1, 2'd0);
        cyc();
        adv(); rst = 1'b0; set_all(4'b0100, 2'd1, 2'd3);
        cyc(); adv();
        cyc(); check("t5_busy_mid", 8'(io_busy), 8'd1); adv();
        rst = 1'b1;
        cyc(); adv();
        rst = 1'b0; set_all(4'b1011, 2'd1, 2'd0);
        cyc();
        check("t5_busy_after", 8'(io_busy), 8'd0);
        check("t5_lastgrant_reset", 8'(io_chosen), 8'd1);
        check("t5_err_after", 8'(io_credit_err), 8'd0);
        for (int i = 0; i < 4; i++) begin
            adv(); cyc();
            check("t5_credit_restored", 8'(io_out_valid), 8'((i < 3) ? 1 : 0));
        end

`ifdef CORERISCV_AXI4_ARB_WATCHDOG_EN
        // locked owner stalls long enough to trip the watchdog
        adv(); rst = 1'b1; set_all(4'b0000, 2'd0, 2'd0);
        cyc();
        adv(); rst = 1'b0; set_all(4'b0001, 2'd0, 2'd1);
        cyc(); adv(); vld = 4'b0000;
        for (int k = 0; k < 260; k++) begin
            cyc();
            if (k == 240) check("wd_not_yet", 8'(io_lock_timeout), 8'd0);
            adv();
        end
        cyc();
        check("wd_timeout", 8'(io_lock_timeout), 8'd1);
        check("wd_still_busy", 8'(io_busy), 8'd1);
`endif

        adv();
        check("sb_drained", 8'(sb.size()), 8'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/coreriscv_axi4_credit_lrr_arbiter.md
Name: coreriscv_axi4_credit_lrr_arbiter

Overview:
- Four-requester, locking round-robin arbiter for multi-beat tile-link style messages onto one shared output channel.
- Holds a grant from a message's first beat through its last beat.
- Gates new grants with per-destination credit counters, so a destination's buffer is never oversubscribed.
- Sits between client-side message sources and the shared network port, in front of the existing header/xact-id datapath.

Parameters:
- CREDITS, 4: initial and maximum credit count per destination (1..7).
- TIMEOUT, 255: watchdog cycle limit while locked (used only with the optional feature).

Ports:
- clk  input  1  clock.
- reset  input  1  reset; synchronous, active-high.
- io_in_N_valid  input  1  request valid, N=0..3.
- io_in_N_ready  output  1  beat accepted from input N.
- io_in_N_bits_header_src  input  2  source id.
- io_in_N_bits_header_dst  input  2  destination id; selects the credit counter.
- io_in_N_bits_payload_manager_xact_id  input  2  transaction id.
- io_in_N_bits_payload_len  input  2  beats minus one (0..3 gives 1..4 beats); sampled on the first beat only.
- io_out_ready  input  1  downstream ready.
- io_out_valid  output  1  beat valid.
- io_out_bits_header_src, io_out_bits_header_dst, io_out_bits_payload_manager_xact_id  output  2 each  muxed fields.
- io_out_last  output  1  current beat is the message's final beat.
- io_chosen  output  2  selected input index.
- io_credit_return_valid  input  1  one credit returned.
- io_credit_return_dst  input  2  destination of the returned credit.
- io_busy  output  1  arbiter is in LOCKED.
- io_credit_err  output  1  sticky: credit return while the counter is already at CREDITS.

Behaviour:
- Reset values: state=IDLE, lastGrant=0, beat_cnt=0, locked_idx=0, all credit[d]=CREDITS, io_credit_err=0.
- Reset outputs: io_busy=0, io_chosen=0; ready, valid and last follow the combinational rules below with these state values.
- Reset has priority over every other event. A message in progress at reset is abandoned and no credit is restored for it.
- Eligibility: input N is eligible when io_in_N_valid=1 and credit[io_in_N_bits_header_dst]!=0.
- IDLE choice, combinational:
  - First pick: lowest N > lastGrant that is eligible.
  - Otherwise: lowest eligible N.
  - Otherwise: io_chosen=0 and io_out_valid=0.
- IDLE outputs: io_out_valid = the chosen input is eligible. io_in_N_ready = io_out_ready & (N==io_chosen) & eligible(N). io_out_last = (len==0).
- IDLE fire (io_out_valid & io_out_ready), in the same cycle:
  - lastGrant <= io_chosen.
  - credit[dst] decrements.
  - If len!=0: locked_idx <= io_chosen, beat_cnt <= len-1, state <= LOCKED.
  - If len==0: stay in IDLE.
- LOCKED outputs: io_chosen=locked_idx. io_out_valid = io_in_locked_valid (no credit check). Data fields are muxed from locked_idx. io_in_N_ready = io_out_ready & (N==locked_idx). io_out_last = (beat_cnt==0).
- LOCKED fire: if beat_cnt==0, go to IDLE; otherwise beat_cnt decrements. Other inputs see ready=0 throughout.
- Earliest new grant: the cycle after a last-beat fire. No zero-cycle handoff.
- Combinational path: io_out_ready to io_in_N_ready.
- Credit update per destination each cycle: next = credit - dec + inc.
  - Decrement and return to the same destination in one cycle: value unchanged.
  - Return when credit==CREDITS with no decrement in that cycle: value saturates, io_credit_err <= 1 (cleared only by reset).
  - Counter width is 3 bits.
- io_busy = (state==LOCKED).

Optional Feature:
- Macro: CORERISCV_AXI4_ARB_WATCHDOG_EN.
- Defined:
  - Adds output io_lock_timeout (1 bit, sticky, reset 0) and an 8-bit stall counter.
  - The stall counter clears on any fire and on entry to IDLE. It increments each LOCKED cycle with no fire.
  - When the counter reaches TIMEOUT, io_lock_timeout <= 1. The arbiter keeps its lock.
- Undefined: no counter and no port; behaviour is otherwise identical.

Test Plan:
- After reset, inputs 0 and 2 valid, each len=0, dst=1, out_ready=1 → cycle 1 grants 2 (lastGrant=0, so 2>0), cycle 2 grants 0; credit[1] goes 4→3→2.
- Input 1 with len=3, input 3 valid and eligible throughout → io_chosen=1 for 4 fires, io_out_last only on the 4th, io_in_3_ready=0 for all 4; input 3 is granted on the next cycle.
- dst=2 with credit drained to 0 by four len=0 messages; input 0 requests dst=2 → io_out_valid=0. Pulse credit_return dst=2 → grant the following cycle, credit 1→0.
- Same cycle: decrement of dst=3 and return of dst=3 at credit 2 → credit stays 2. Return to dst=0 at credit 4 → stays 4 and io_credit_err=1.
- LOCKED mid-message (beat 2 of 4), reset asserted for one cycle → next cycle io_busy=0, credits all 4, lastGrant=0.
- With the macro defined: locked, input valid=0 for 255 cycles → io_lock_timeout=1 and io_busy still 1. Undefined: the port is absent.
